vga_frame_monitor: RTL and testbench

//  Receive-side checker for the VGA stream produced by draw.

---
 rtl/vga_frame_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// ---------------------------------------------------------------------------
// vga_frame_monitor
//
// Receive-side checker for a VGA raster stream. For every frame delimited by
// two vsync edges it reports a CRC-16-CCITT of the active pixels, the number
// of active lines, the pixel count of the final active line, a frame counter
// and timing error flags measured against the nominal raster geometry.
//
// Optional feature macro: VGA_MON_CRC_EN
//   defined   -> CRC engine present, frame_crc carries the frame CRC
//   undefined -> CRC engine removed, frame_crc is held at 16'h0000
//
// Parameters
//   H_ACTIVE  active pixels per line
//   V_ACTIVE  active lines per frame
//   H_TOTAL   clocks per hsync period
//   V_TOTAL   lines per vsync period
//   SYNC_POL  asserted level of hsync / vsync
//
// Ports
//   clk           pixel clock
//   rst           asynchronous reset, active-high
//   hsync, vsync  sync inputs (asserted level = SYNC_POL)
//   hblnk, vblnk  blanking inputs, pixel is active when both are low
//   rgb[11:0]     pixel {r,g,b}
//   frame_done    one-cycle pulse, the frame_* outputs were just updated
//   frame_crc     CRC of the last complete frame
//   frame_lines   lines with at least one active pixel in the last frame
//   last_line_px  active pixels on the final active line of the last frame
//   frame_count   completed frames, wraps
//   err_flags     [0] hsync period [1] pixels/line [2] line count [3] vsync period
//   sticky_err    OR of every err_flags value reported since reset
// ---------------------------------------------------------------------------
module vga_frame_monitor #(
    parameter int   H_ACTIVE = 1024,
    parameter int   V_ACTIVE = 768,
    parameter int   H_TOTAL  = 1328,
    parameter int   V_TOTAL  = 806,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic [11:0] rgb,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic [11:0] frame_lines,
    output logic [11:0] last_line_px,
    output logic [15:0] frame_count,
    output logic [3:0]  err_flags,
    output logic [3:0]  sticky_err
);

    localparam logic [11:0] H_ACTIVE_W = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACTIVE_W = 12'(V_ACTIVE);
    localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
    localparam logic [20:0] V_PERIOD   = 21'(H_TOTAL * V_TOTAL);
    localparam logic [11:0] HS_MAX     = 12'hFFF;
    localparam logic [20:0] VS_MAX     = 21'h1F_FFFF;

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t state;
    state_t state_next;

    // Two register stages on the inputs. Sync regs idle at the deasserted
    // level and blanking regs idle blanked, so leaving reset never produces
    // a phantom edge or a phantom line end.
    logic hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
    logic hsync_s2, vsync_s2, hblnk_s2, vblnk_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_s1 <= ~SYNC_POL;
            vsync_s1 <= ~SYNC_POL;
            hblnk_s1 <= 1'b1;
            vblnk_s1 <= 1'b1;
            hsync_s2 <= ~SYNC_POL;
            vsync_s2 <= ~SYNC_POL;
            hblnk_s2 <= 1'b1;
            vblnk_s2 <= 1'b1;
        end else begin
            hsync_s1 <= hsync;
            vsync_s1 <= vsync;
            hblnk_s1 <= hblnk;
            vblnk_s1 <= vblnk;
            hsync_s2 <= hsync_s1;
            vsync_s2 <= vsync_s1;
            hblnk_s2 <= hblnk_s1;
            vblnk_s2 <= vblnk_s1;
        end
    end

    // Event detection. A line end is the first inactive cycle that follows
    // an active one, so it can never coincide with an active pixel.
    logic hs_edge, vs_edge, active_s1, active_s2, line_end;

    always_comb begin
        hs_edge   = (hsync_s1 == SYNC_POL) && (hsync_s2 != SYNC_POL);
        vs_edge   = (vsync_s1 == SYNC_POL) && (vsync_s2 != SYNC_POL);
        active_s1 = !hblnk_s1 && !vblnk_s1;
        active_s2 = !hblnk_s2 && !vblnk_s2;
        line_end  = active_s2 && !active_s1;
    end

    // Events are registered once more so every frame decision is made from
    // flops; this stage sets the vsync-to-frame_done latency to three clocks.
    logic hs_edge_q, vs_edge_q, active_q, line_end_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_edge_q  <= 1'b0;
            vs_edge_q  <= 1'b0;
            active_q   <= 1'b0;
            line_end_q <= 1'b0;
        end else begin
            hs_edge_q  <= hs_edge;
            vs_edge_q  <= vs_edge;
            active_q   <= active_s1;
            line_end_q <= line_end;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first vsync edge only opens a frame; every later one closes the
    // running frame and opens the next.
    logic frame_start, frame_end;

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (vs_edge_q) begin
                    state_next  = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                if (vs_edge_q) begin
                    frame_end = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-frame accumulators.
    logic [11:0] px_cnt;
    logic [11:0] line_cnt;
    logic [11:0] last_px;
    logic [1:0]  err_acc;
    logic [11:0] hs_cnt;
    logic        hs_armed;
    logic [20:0] vs_cnt;

    // Values a frame closes with. A line end landing on the closing vsync
    // edge still belongs to the closing frame.
    logic        px_err, hs_err;
    logic [11:0] lines_final;
    logic [11:0] last_px_final;
    logic [3:0]  err_final;

    always_comb begin
        px_err        = line_end_q && (px_cnt != H_ACTIVE_W);
        hs_err        = hs_edge_q && hs_armed && (hs_cnt != H_TOTAL_W);
        lines_final   = line_cnt + 12'(line_end_q);
        last_px_final = line_end_q ? px_cnt : last_px;
        err_final     = {vs_cnt != V_PERIOD,
                         lines_final != V_ACTIVE_W,
                         err_acc[1] | px_err,
                         err_acc[0] | hs_err};
    end

    // Pixel / line bookkeeping. A pixel on the vsync edge cycle opens the
    // new frame, so the fresh pixel count starts at one in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_cnt   <= '0;
            line_cnt <= '0;
            last_px  <= '0;
            err_acc  <= '0;
        end else if (frame_start || frame_end) begin
            px_cnt   <= active_q ? 12'd1 : 12'd0;
            line_cnt <= '0;
            last_px  <= '0;
            err_acc  <= '0;
        end else if (state == FRAME) begin
            if (active_q) begin
                px_cnt <= px_cnt + 12'd1;
            end
            if (line_end_q) begin
                px_cnt   <= '0;
                line_cnt <= line_cnt + 12'd1;
                last_px  <= px_cnt;
            end
            err_acc <= err_acc | {px_err, hs_err};
        end
    end

    // Sync period counters run continuously and restart at one on each edge,
    // so the count seen on the next edge equals the period in clocks. Both
    // saturate so a lost pulse still reads as a wrong period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_cnt   <= '0;
            hs_armed <= 1'b0;
            vs_cnt   <= '0;
        end else begin
            if (hs_edge_q) begin
                hs_cnt <= 12'd1;
            end else if (hs_cnt != HS_MAX) begin
                hs_cnt <= hs_cnt + 12'd1;
            end

            if (vs_edge_q) begin
                vs_cnt <= 21'd1;
            end else if (vs_cnt != VS_MAX) begin
                vs_cnt <= vs_cnt + 21'd1;
            end

            // The period seen at the first hsync edge of a fresh frame spans
            // time spent in IDLE, so that edge only arms the check.
            if (frame_start) begin
                hs_armed <= 1'b0;
            end else if (state == FRAME && hs_edge_q) begin
                hs_armed <= 1'b1;
            end
        end
    end

    // Frame report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done   <= 1'b0;
            frame_lines  <= '0;
            last_line_px <= '0;
            frame_count  <= '0;
            err_flags    <= '0;
            sticky_err   <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_lines  <= lines_final;
                last_line_px <= last_px_final;
                frame_count  <= frame_count + 16'd1;
                err_flags    <= err_final;
                sticky_err   <= sticky_err | err_final;
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    // CRC-16-CCITT (poly 0x1021), twelve bits per pixel, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [11:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [11:0] rgb_s1;
    logic [11:0] rgb_q;
    logic [15:0] crc_acc;

    // Pixel data follows the same pipeline depth as the active flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_s1 <= '0;
            rgb_q  <= '0;
        end else begin
            rgb_s1 <= rgb;
            rgb_q  <= rgb_s1;
        end
    end

    // The running CRC restarts at every frame boundary, seeded with the
    // boundary-cycle pixel when there is one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= '0;
        end else begin
            if (frame_start || frame_end) begin
                crc_acc <= active_q ? crc_step(16'hFFFF, rgb_q) : 16'hFFFF;
            end else if (state == FRAME && active_q) begin
                crc_acc <= crc_step(crc_acc, rgb_q);
            end
            if (frame_end) begin
                frame_crc <= crc_acc;
            end
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_monitor
//
// Drives a small raster (4x2 active, 8 clocks per line, 4 lines per frame)
// into vga_frame_monitor. Each applyStimulus call emits one frame starting
// with its vsync line; the expected report of a frame is queued when the
// vsync edge that closes it is driven, and an independent monitor pops and
// compares whenever frame_done is seen.
// ---------------------------------------------------------------------------
module tb_vga_frame_monitor;

    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;
    localparam int H_TOTAL  = 8;
    localparam int V_TOTAL  = 4;

    logic        clk;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic [11:0] frame_lines;
    logic [11:0] last_line_px;
    logic [15:0] frame_count;
    logic [3:0]  err_flags;
    logic [3:0]  sticky_err;

    vga_frame_monitor #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .SYNC_POL (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hsync        (hsync),
        .vsync        (vsync),
        .hblnk        (hblnk),
        .vblnk        (vblnk),
        .rgb          (rgb),
        .frame_done   (frame_done),
        .frame_crc    (frame_crc),
        .frame_lines  (frame_lines),
        .last_line_px (last_line_px),
        .frame_count  (frame_count),
        .err_flags    (err_flags),
        .sticky_err   (sticky_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] crc;
        logic [11:0] lines;
        logic [11:0] lpx;
        logic [15:0] count;
        logic [3:0]  err;
        logic [3:0]  sticky;
    } exp_t;

    exp_t sb_q[$];
    exp_t pending;
    exp_t mon_e;
    bit   have_pending = 0;
    bit   in_frame = 0;
    logic [15:0] m_count = '0;
    logic [3:0]  m_sticky = '0;

    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] crc_model(input logic [15:0] c,
                                              input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_done"},  32'(frame_done),   32'd0);
        checkOutput({tag, "_crc"},   32'(frame_crc),    32'd0);
        checkOutput({tag, "_lines"}, 32'(frame_lines),  32'd0);
        checkOutput({tag, "_lpx"},   32'(last_line_px), 32'd0);
        checkOutput({tag, "_count"}, 32'(frame_count),  32'd0);
        checkOutput({tag, "_err"},   32'(err_flags),    32'd0);
        checkOutput({tag, "_sticky"},32'(sticky_err),   32'd0);
    endtask

    // One frame: line 0 carries vsync, lines 1-2 are active rows 0-1,
    // line 3 (plus 'extra' lines) blank. hsync pulses at h==5 of each line.
    // Fault knobs use -1 for "off".
    task automatic applyStimulus(input logic [11:0] color, input int short_row,
                                 input int drop_ln, input bit flip,
                                 input int blank_row, input int extra,
                                 input int reset_ln);
        logic [15:0] crc = 16'hFFFF;
        int          lines = 0;
        int          cur_px = 0;
        int          last_px = 0;
        logic [3:0]  err = 4'b0000;
        logic [11:0] pix;
        int          a;
        bit          act;
        for (int ln = 0; ln < 4 + extra; ln++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                @(posedge clk);
                #1;
                a     = (ln >= 1 && ln <= 2) ? ln - 1 : -1;
                act   = (a >= 0) && (a != blank_row);
                vsync = (ln == 0) ? 1'b0 : 1'b1;
                hsync = (h == 5 && ln != drop_ln) ? 1'b0 : 1'b1;
                vblnk = !act;
                hblnk = (h >= H_ACTIVE) || (a == short_row && h == H_ACTIVE - 1);
                pix   = color;
                if (flip && a == 1 && h == 1) pix = pix ^ 12'h001;
                rgb   = pix;
                if (act && !hblnk) begin
                    crc = crc_model(crc, pix);
                    cur_px++;
                end else if (cur_px > 0) begin
                    lines++;
                    last_px = cur_px;
                    if (cur_px != H_ACTIVE) err[1] = 1'b1;
                    cur_px = 0;
                end
                if (ln == 0 && h == 0) begin
                    if (in_frame && have_pending) begin
                        m_count++;
                        m_sticky       = m_sticky | pending.err;
                        pending.due    = cyc + 3;
                        pending.count  = m_count;
                        pending.sticky = m_sticky;
                        sb_q.push_back(pending);
                    end
                    have_pending = 0;
                    in_frame     = 1;
                end
                if (ln == reset_ln && h == 2) begin
                    rst          = 1'b1;
                    in_frame     = 0;
                    have_pending = 0;
                    m_count      = '0;
                    m_sticky     = '0;
                    #1;
                    checkAllZero("midreset");
                end else begin
                    rst = 1'b0;
                end
            end
        end
        if (drop_ln >= 1) err[0] = 1'b1;
        if (lines != V_ACTIVE) err[2] = 1'b1;
        if (extra > 0) err[3] = 1'b1;
        if (in_frame) begin
`ifdef VGA_MON_CRC_EN
            pending.crc = crc;
`else
            pending.crc = 16'h0000;
`endif
            pending.lines = 12'(lines);
            pending.lpx   = 12'(last_px);
            pending.err   = err;
            have_pending  = 1;
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (frame_done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(frame_done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("done_cycle", 32'(cyc),          32'(mon_e.due));
                checkOutput("frame_crc",  32'(frame_crc),    32'(mon_e.crc));
                checkOutput("frame_lines",32'(frame_lines),  32'(mon_e.lines));
                checkOutput("last_px",    32'(last_line_px), 32'(mon_e.lpx));
                checkOutput("frame_count",32'(frame_count),  32'(mon_e.count));
                checkOutput("err_flags",  32'(err_flags),    32'(mon_e.err));
                checkOutput("sticky_err", 32'(sticky_err),   32'(mon_e.sticky));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        hblnk = 1'b1;
        vblnk = 1'b1;
        rgb   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] clean frames and single pixel change");
        applyStimulus(12'hABC, -1, -1, 0, -1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 0, -1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 1, -1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 0, -1, 0, -1);

        $display("[TB] short line, missing hsync, missing line, long frame");
        applyStimulus(12'hABC,  1, -1, 0, -1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 0, -1, 0, -1);
        applyStimulus(12'hABC, -1,  1, 0, -1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 0,  1, 0, -1);
        applyStimulus(12'hABC, -1, -1, 0, -1, 1, -1);
        applyStimulus(12'hABC, -1, -1, 0, -1, 0, -1);

        $display("[TB] reset mid-frame");
        applyStimulus(12'hABC, -1, -1, 0, -1, 0,  1);
        applyStimulus(12'h5A3, -1, -1, 0, -1, 0, -1);
        applyStimulus(12'h5A3, -1, -1, 0, -1, 0, -1);
        applyStimulus(12'h0F0, -1, -1, 0, -1, 0, -1);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checkOutput("pending_done", 32'(sb_q.size()), 32'd0);
        end
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
